// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

  // Sliced down to INST_WIDTH by the fetch unit (INST_WIDTH <= 64).
  localparam logic [63:0] DEFAULT_HALT_WORD = '1;

  // Sequential PC with wrap to 0 after the last ROM word.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] max);
    return (pc == max - 32'd1) ? 32'd0 : pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM port, IF/ID handshake, redirect and status.
interface fetch_unit_if #(
  parameter int INST_WIDTH = 32,
  parameter int AW         = 7
);
  logic                  run;
  logic [AW-1:0]         rom_address;
  logic [INST_WIDTH-1:0] rom_instruction;
  logic                  if_valid;
  logic                  id_ready;
  logic [INST_WIDTH-1:0] if_instruction;
  logic [AW-1:0]         if_pc;
  logic                  redirect;
  logic [AW-1:0]         redirect_pc;
  logic                  halted;
  logic                  fault;
  logic [31:0]           fetch_count;

  modport master (
    input  run, rom_instruction, id_ready, redirect, redirect_pc,
    output rom_address, if_valid, if_instruction, if_pc, halted, fault, fetch_count
  );

  modport slave (
    output run, rom_instruction, id_ready, redirect, redirect_pc,
    input  rom_address, if_valid, if_instruction, if_pc, halted, fault, fetch_count
  );
endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: sequential advance with wrap, redirect load, range check on redirect target.
module pc_counter import fetch_pkg::*; #(
  parameter int MAX_NUM_INST = 128,
  parameter int RESET_PC     = 0,
  parameter int AW           = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_pc_i,
  output logic [AW-1:0] pc_o,
  output logic          range_err_o
);
  logic [AW-1:0] pc_q, pc_d;

  assign range_err_o = 32'(load_pc_i) >= 32'(MAX_NUM_INST);
  assign pc_o        = pc_q;

  // Out-of-range targets are never loaded, so the ROM index stays legal.
  always_comb begin
    pc_d = pc_q;
    if (load_i && !range_err_o) pc_d = load_pc_i;
    else if (inc_i)             pc_d = AW'(next_pc(32'(pc_q), 32'(MAX_NUM_INST)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= AW'(RESET_PC);
    else        pc_q <= pc_d;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC drives a combinational ROM, word captured into IF/ID
// under valid/ready, with redirect/flush and HALT-word stop.
module fetch_unit import fetch_pkg::*; #(
  parameter int INST_WIDTH   = 32,
  parameter int MAX_NUM_INST = 128,
  parameter int RESET_PC     = 0,
  parameter logic [INST_WIDTH-1:0] HALT_WORD = DEFAULT_HALT_WORD[INST_WIDTH-1:0]
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int AW = (MAX_NUM_INST > 1) ? $clog2(MAX_NUM_INST) : 1;

  fetch_state_t          state_q, state_d;
  logic                  if_valid_q, if_valid_d;
  logic [INST_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [AW-1:0]         if_pc_q, if_pc_d;
  logic                  fault_q, fault_d;
  logic [31:0]           count_q, count_d;
  logic [AW-1:0]         pc;
  logic                  pc_inc, pc_load, range_err, load, accept;

  pc_counter #(.MAX_NUM_INST(MAX_NUM_INST), .RESET_PC(RESET_PC), .AW(AW)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_pc_i  (bus.redirect_pc),
    .pc_o       (pc),
    .range_err_o(range_err)
  );

  assign load   = !if_valid_q || bus.id_ready;
  assign accept = if_valid_q && bus.id_ready && !bus.redirect;

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    count_d    = (accept && count_q != '1) ? count_q + 32'd1 : count_q;

    // Draining: an accepted word leaves IF/ID unless replaced below.
    if (bus.id_ready) if_valid_d = 1'b0;

    unique case (state_q)
      IDLE: if (bus.run) state_d = RUN;
      RUN: begin
        if (bus.redirect) begin
          if_valid_d = 1'b0;
          if (range_err) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_load = 1'b1;
          end
        end else if (load) begin
          if_valid_d = 1'b1;
          if_instr_d = bus.rom_instruction;
          if_pc_d    = pc;
          if (bus.rom_instruction == HALT_WORD) state_d = HALT;
          else                                  pc_inc  = 1'b1;
        end
      end
      HALT: begin
        // Redirect here flushes only; fetching never restarts without reset.
        if (bus.redirect) begin
          if_valid_d = 1'b0;
          if (range_err) fault_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign bus.rom_address    = pc;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_instruction = if_instr_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.halted         = (state_q == HALT);
  assign bus.fault          = fault_q;
  assign bus.fetch_count    = count_q;
endmodule
